// File: rtl/obi_data_arbiter.sv
// Round-robin arbiter merging several OBI data requesters onto one downstream port.
// Responses are routed back in order through a small source-id FIFO.
module obi_data_arbiter #(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned AddrWidth      = 56,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NumReq-1:0]                     req_i,
  output logic [NumReq-1:0]                     gnt_o,
  input  logic [NumReq-1:0][AddrWidth-1:0]      addr_i,
  input  logic [NumReq-1:0]                     we_i,
  input  logic [NumReq-1:0][DataWidth/8-1:0]    be_i,
  input  logic [NumReq-1:0][DataWidth-1:0]      wdata_i,
  input  logic [NumReq-1:0][5:0]                atop_i,
  output logic [NumReq-1:0]                     rvalid_o,
  input  logic [NumReq-1:0]                     rready_i,
  output logic [DataWidth-1:0]                  rdata_o,
  output logic                                  err_o,
  output logic                                  req_o,
  input  logic                                  gnt_i,
  output logic [AddrWidth-1:0]                  addr_o,
  output logic                                  we_o,
  output logic [DataWidth/8-1:0]                be_o,
  output logic [DataWidth-1:0]                  wdata_o,
  output logic [5:0]                            atop_o,
  input  logic                                  rvalid_i,
  input  logic [DataWidth-1:0]                  rdata_i,
  input  logic                                  err_i,
  output logic                                  rready_o
);

  // state    | meaning
  // ARB      | pick next requester round-robin, pass its request through
  // HOLD     | request issued without grant; selection and payload frozen
  // AMO_WAIT | atomic in flight alone; no new requests until its response
  typedef enum logic [1:0] {ARB, HOLD, AMO_WAIT} state_e;

  localparam int unsigned SelW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned IdxW = SelW + 1;
  localparam int unsigned PtrW = $clog2(MaxOutstanding);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned BeW  = DataWidth / 8;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [SelW-1:0]       r_rr_ptr;
  logic [SelW-1:0]       r_sel;
  logic [AddrWidth-1:0]  r_addr;
  logic                  r_we;
  logic [BeW-1:0]        r_be;
  logic [DataWidth-1:0]  r_wdata;
  logic [5:0]            r_atop;
  logic [SelW-1:0]       r_fifo [MaxOutstanding];
  logic [PtrW-1:0]       r_wptr;
  logic [PtrW-1:0]       r_rptr;
  logic [CntW-1:0]       r_cnt;

  logic                  w_arb_any;
  logic [SelW-1:0]       w_arb_sel;
  logic [IdxW-1:0]       w_idx;
  logic [SelW-1:0]       w_sel;
  logic [SelW-1:0]       w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_amo;
  logic                  w_req;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_rready;

  always_comb begin
    w_arb_any = 1'b0;
    w_arb_sel = '0;
    w_idx     = '0;
    for (int i = 0; i < NumReq; i++) begin
      w_idx = {1'b0, r_rr_ptr} + IdxW'(i);
      if (w_idx >= IdxW'(NumReq)) w_idx = w_idx - IdxW'(NumReq);
      if (!w_arb_any && req_i[w_idx[SelW-1:0]]) begin
        w_arb_any = 1'b1;
        w_arb_sel = w_idx[SelW-1:0];
      end
    end
  end

  assign w_sel   = (r_state == HOLD) ? r_sel : w_arb_sel;
  assign w_full  = (r_cnt == CntW'(MaxOutstanding));
  assign w_empty = (r_cnt == '0);
  assign w_amo   = (r_state == HOLD) ? (r_atop != '0) : (atop_i[w_arb_sel] != '0);
  assign w_head  = r_fifo[r_rptr];

  // Atomics only leave when nothing else is outstanding, so they complete in isolation.
  always_comb begin
    w_req = 1'b0;
    unique case (r_state)
      ARB:      w_req = w_arb_any && !w_full && (!w_amo || w_empty);
      HOLD:     w_req = 1'b1;
      AMO_WAIT: w_req = 1'b0;
      default:  w_req = 1'b0;
    endcase
  end

  assign w_push   = w_req & gnt_i;
  assign w_rready = w_empty ? 1'b1 : rready_i[w_head];
  assign w_pop    = rvalid_i & w_rready & ~w_empty;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ARB: begin
        if (w_req) w_state_nxt = gnt_i ? (w_amo ? AMO_WAIT : ARB) : HOLD;
      end
      HOLD: begin
        if (gnt_i) w_state_nxt = w_amo ? AMO_WAIT : ARB;
      end
      AMO_WAIT: begin
        if (w_pop) w_state_nxt = ARB;
      end
      default: w_state_nxt = ARB;
    endcase
  end

  always_comb begin
    req_o    = 1'b0;
    gnt_o    = '0;
    addr_o   = '0;
    we_o     = 1'b0;
    be_o     = '0;
    wdata_o  = '0;
    atop_o   = '0;
    rvalid_o = '0;
    rready_o = 1'b1;
    rdata_o  = '0;
    err_o    = 1'b0;
    if (!rst_i) begin
      req_o        = w_req;
      gnt_o[w_sel] = w_push;
      if (r_state == HOLD) begin
        addr_o  = r_addr;
        we_o    = r_we;
        be_o    = r_be;
        wdata_o = r_wdata;
        atop_o  = r_atop;
      end else begin
        addr_o  = addr_i[w_arb_sel];
        we_o    = we_i[w_arb_sel];
        be_o    = be_i[w_arb_sel];
        wdata_o = wdata_i[w_arb_sel];
        atop_o  = atop_i[w_arb_sel];
      end
      rvalid_o[w_head] = rvalid_i & ~w_empty;
      rready_o         = w_rready;
      rdata_o          = rdata_i;
      err_o            = err_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ARB;
      r_rr_ptr <= '0;
      r_sel    <= '0;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_be     <= '0;
      r_wdata  <= '0;
      r_atop   <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Snapshot every ARB cycle so HOLD replays exactly what was first presented.
      if (r_state == ARB) begin
        r_sel   <= w_arb_sel;
        r_addr  <= addr_i[w_arb_sel];
        r_we    <= we_i[w_arb_sel];
        r_be    <= be_i[w_arb_sel];
        r_wdata <= wdata_i[w_arb_sel];
        r_atop  <= atop_i[w_arb_sel];
      end
      if (w_push) begin
        r_rr_ptr <= (w_sel == SelW'(NumReq - 1)) ? '0 : w_sel + SelW'(1);
        r_wptr   <= r_wptr + PtrW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PtrW'(1);
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + CntW'(1);
      end else if (w_pop && !w_push) begin
        r_cnt <= r_cnt - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo[r_wptr] <= w_sel;
  end

  a_rsp_without_outstanding: assert property (
    @(posedge clk_i) disable iff (rst_i) !(rvalid_i && w_empty)
  );

endmodule
